// File: rtl/mul_unit.sv
// mul_unit: multi-cycle RV32M multiplier (MUL, MULH, MULHSU, MULHU) in EX.
// The counter and the latched funct3 go to the hazard detection unit, which
// stalls the front of the pipe until the op's completion value is reached.
// Optional macro MUL_ZERO_SKIP_EN: if either operand is zero at start, the
// arithmetic steps are skipped (counter 1 -> 5) while completion timing is kept.
module mul_unit #(
  parameter int unsigned LAT_LO = 6,
  parameter int unsigned LAT_HI = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mul,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [2:0]  counter,
  output logic [2:0]  op_funct3,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned CW   = 3;   // counter width
  localparam int unsigned OPW  = 33;  // sign-extended operand width
  localparam int unsigned CHW  = 10;  // signed chunk width (9-bit chunk + sign)
  localparam int unsigned PPW  = 43;  // partial product width (OPW + CHW)
  localparam int unsigned ACCW = 66;  // accumulator width

  logic [OPW-1:0]  a_q;
  logic [OPW-1:0]  b_q;
  logic [ACCW-1:0] acc_q;
`ifdef MUL_ZERO_SKIP_EN
  logic            skip_q;
`endif

  logic                   a_sgn_c;
  logic                   b_sgn_c;
  logic                   lo_lat_c;
  logic                   sel_low_c;
  logic [CW-1:0]          lat_c;
  logic [CW-1:0]          cnt_inc_c;
  logic [CHW-1:0]         chunk_c;
  logic signed [PPW-1:0]  a_ext_c;
  logic signed [PPW-1:0]  chunk_ext_c;
  logic signed [PPW-1:0]  pp_c;
  logic [ACCW-1:0]        pp_ext_c;
  logic [ACCW-1:0]        addend_c;

  // Operand signedness at start; illegal funct3 (bit 2 set) behaves as MUL.
  assign a_sgn_c = (funct3 != 3'b011);
  assign b_sgn_c = funct3[2] | ~funct3[1];

  // Completion value and result half for the latched op.
  assign lo_lat_c  = op_funct3[2] | ~op_funct3[1];
  assign sel_low_c = op_funct3[2] | (op_funct3[1:0] == 2'b00);
  assign lat_c     = lo_lat_c ? CW'(LAT_LO) : CW'(LAT_HI);
  assign cnt_inc_c = counter + CW'(1);

  // Pick this step's chunk of B and form the shifted partial product.
  always_comb begin
    chunk_c  = '0;
    addend_c = '0;
    case (counter)
      3'd1:    chunk_c = {2'b00, b_q[7:0]};
      3'd2:    chunk_c = {2'b00, b_q[15:8]};
      3'd3:    chunk_c = {2'b00, b_q[23:16]};
      3'd4:    chunk_c = {b_q[32], b_q[32:24]};
      default: chunk_c = '0;
    endcase
    a_ext_c     = $signed({{(PPW-OPW){a_q[OPW-1]}}, a_q});
    chunk_ext_c = $signed({{(PPW-CHW){chunk_c[CHW-1]}}, chunk_c});
    pp_c        = a_ext_c * chunk_ext_c;
    pp_ext_c    = {{(ACCW-PPW){pp_c[PPW-1]}}, pp_c};
    case (counter)
      3'd1:    addend_c = pp_ext_c;
      3'd2:    addend_c = pp_ext_c << 8;
      3'd3:    addend_c = pp_ext_c << 16;
      3'd4:    addend_c = pp_ext_c << 24;
      default: addend_c = '0;
    endcase
  end

  // Sequencer: start, accumulate, load result, hold, complete or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      op_funct3 <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
`ifdef MUL_ZERO_SKIP_EN
      skip_q    <= 1'b0;
`endif
    end else if (counter == '0) begin
      done <= 1'b0;
      if (mul && !kill) begin
        op_funct3 <= funct3;
        a_q       <= {a_sgn_c & rs1_data[31], rs1_data};
        b_q       <= {b_sgn_c & rs2_data[31], rs2_data};
        acc_q     <= '0;
        counter   <= CW'(1);
        busy      <= 1'b1;
`ifdef MUL_ZERO_SKIP_EN
        skip_q    <= (rs1_data == '0) || (rs2_data == '0);
`endif
      end
    end else if (kill || done) begin
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (counter)
        3'd1, 3'd2, 3'd3, 3'd4: begin
`ifdef MUL_ZERO_SKIP_EN
          if (skip_q) begin
            counter <= CW'(5);
            result  <= '0;
          end else begin
            acc_q   <= acc_q + addend_c;
            counter <= cnt_inc_c;
          end
`else
          acc_q   <= acc_q + addend_c;
          counter <= cnt_inc_c;
`endif
        end
        3'd5: begin
          result  <= sel_low_c ? acc_q[31:0] : acc_q[63:32];
          counter <= cnt_inc_c;
          done    <= (cnt_inc_c == lat_c);
        end
        3'd6: begin
          counter <= cnt_inc_c;
          done    <= (cnt_inc_c == lat_c);
        end
        default: begin
          counter <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: scoreboard bench for mul_unit with directed, hand-computed vectors.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mul;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [2:0]  counter;
  logic [2:0]  op_funct3;
  logic        busy;
  logic        done;
  logic [31:0] result;

  mul_unit #(.LAT_LO(6), .LAT_HI(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .mul       (mul),
    .kill      (kill),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .counter   (counter),
    .op_funct3 (op_funct3),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected transaction.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_counter", 32'(counter), 32'(e.lat));
      end
    end
  end

  // Drive an op and wait until the DUT shows counter==1; waits = edges taken.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] res, output int waits);
    exp_t e;
    @(negedge clk);
    mul = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    if (push) begin
      e.res = res;
      e.lat = (f[2] | ~f[1]) ? 3'd6 : 3'd7;
      sb.push_back(e);
    end
    waits = 0;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (!(busy === 1'b1 && counter === 3'd1) && waits < 10);
    check("start_counter", 32'(counter), 32'(1));
  endtask

  // Count edges from start until done; n0 is edges already elapsed.
  task automatic wait_done(input int lat, input int n0);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res);
    int w;
    start_op(f, a, b, 1'b1, res, w);
    wait_done((f[2] | ~f[1]) ? 6 : 7, 1);
    @(negedge clk);
    mul = 1'b0;
  endtask

  initial begin
    int w;
    reset = 1'b1; mul = 1'b0; kill = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_counter", 32'(counter), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", result, 32'h0);
    check("rst_op_funct3", 32'(op_funct3), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // MUL 7*6 with mul held through done; idle the cycle after.
    start_op(3'b000, 32'd7, 32'd6, 1'b1, 32'h0000002A, w);
    wait_done(6, 1);
    @(posedge clk); #1;
    check("after_done_counter", 32'(counter), 32'(0));
    check("after_done_busy", 32'(busy), 32'(0));
    check("after_done_done", 32'(done), 32'(0));
    @(negedge clk);
    mul = 1'b0;

    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    run_op(3'b011, 32'h80000000, 32'h00000003, 32'h00000001);
    run_op(3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1);
    run_op(3'b100, 32'd9, 32'd9, 32'h00000051);
    run_op(3'b000, 32'h0, 32'h00001234, 32'h00000000);
    run_op(3'b011, 32'h00001234, 32'h0, 32'h00000000);

    // Inputs changed mid-operation are ignored.
    start_op(3'b000, 32'h12345678, 32'h00000100, 1'b1, 32'h34567800, w);
    @(posedge clk); #1;
    @(negedge clk);
    rs1_data = 32'hFFFFFFFF; rs2_data = 32'd7; funct3 = 3'b011;
    #1;
    check("op_funct3_held", 32'(op_funct3), 32'(0));
    wait_done(6, 2);
    @(negedge clk);
    mul = 1'b0;

    // Back-to-back MULs: exactly one idle cycle between them.
    start_op(3'b000, 32'd3, 32'd5, 1'b1, 32'd15, w);
    wait_done(6, 1);
    start_op(3'b000, 32'd4, 32'd4, 1'b1, 32'd16, w);
    check("b2b_gap_edges", 32'(w), 32'(2));
    wait_done(6, 1);
    @(negedge clk);
    mul = 1'b0;

    // Asynchronous reset mid-operation at counter 3.
    start_op(3'b001, 32'h00010000, 32'h00010000, 1'b0, 32'h0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_counter", 32'(counter), 32'(3));
    #2 reset = 1'b1;
    #1;
    check("async_rst_counter", 32'(counter), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0; mul = 1'b0;

    // Kill at counter 4: idle next cycle and no done ever.
    start_op(3'b000, 32'd11, 32'd13, 1'b0, 32'h0, w);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_kill_counter", 32'(counter), 32'(4));
    @(negedge clk);
    kill = 1'b1; mul = 1'b0;
    @(posedge clk); #1;
    check("kill_counter", 32'(counter), 32'(0));
    check("kill_busy", 32'(busy), 32'(0));
    @(negedge clk);
    kill = 1'b0;
    repeat (10) @(posedge clk);

    // Kill together with mul while idle: no start.
    @(negedge clk);
    mul = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    check("kill_nostart_busy", 32'(busy), 32'(0));
    check("kill_nostart_counter", 32'(counter), 32'(0));
    @(negedge clk);
    mul = 1'b0; kill = 1'b0;

    // A normal op still works after the aborts.
    run_op(3'b000, 32'd3, 32'd5, 32'd15);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Multi-cycle RV32M multiplier in the EX stage; executes MUL, MULH, MULHSU and MULHU.
- Exports its cycle counter and the latched funct3 to the hazard detection unit.
- The hazard detection unit stalls PC, IF/ID and ID/EX while the counter is below the op's completion value, then releases the instruction.
- The result is muxed onto the EX result path in the cycle `done` is high.

Parameters:
- LAT_LO, 6, counter value at which funct3[1]==0 ops (MUL, MULH) complete.
- LAT_HI, 7, counter value at which funct3[1]==1 ops (MULHSU, MULHU) complete.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- mul  input  1  ID/EX holds an M-extension multiply; held high for the whole stall
- kill  input  1  EX instruction flushed (mispredict); abort the operation
- funct3  input  3  ID/EX funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- rs1_data  input  32  forwarded operand A
- rs2_data  input  32  forwarded operand B
- counter  output  3  current step, to the hazard detection unit
- op_funct3  output  3  funct3 latched at start, to the hazard detection unit
- busy  output  1  operation in progress
- done  output  1  result valid this cycle
- result  output  32  selected product half

Behaviour:
- Reset (async, any time, including mid-operation):
  - counter=0, busy=0, done=0, result=0, op_funct3=0.
  - Accumulator and operand registers cleared.
- Idle (counter==0) with mul=1 and kill=0 → start:
  - Latch funct3 into op_funct3.
  - Latch operands sign-extended to 33 bits: A signed for MUL/MULH/MULHSU; B signed for MUL/MULH.
  - Clear the 66-bit accumulator; counter←1; busy←1.
- Steps 1..4 (counter 1..4), one chunk of B per cycle:
  - Chunks: B[7:0], B[15:8], B[23:16] as unsigned; B[32:24] as a 9-bit signed chunk.
  - Each step: acc += A × chunk << (8×(counter−1)), 66-bit two's-complement arithmetic.
  - counter increments each step.
- Counter 5:
  - result ← acc[31:0] for MUL, acc[63:32] otherwise.
  - counter←6.
- Completion:
  - done=1 when (op_funct3[1]==0 && counter==LAT_LO) or (op_funct3[1]==1 && counter==LAT_HI).
  - For funct3[1]==1, counter 6 is an idle hold cycle: result is stable, done=0, counter←7.
  - Cycle after done: counter←0, busy←0, done←0. result holds until the next counter-5 load.
- Latency from start edge to done: MUL/MULH 6 cycles, MULHSU/MULHU 7 cycles.
- Operands and funct3 are sampled only at start. Input changes while busy are ignored.
- `mul` remaining high in the done cycle does not restart. A new start needs counter==0, so back-to-back multiplies have exactly one idle cycle between them.
- kill=1 while busy → counter←0, busy←0 next edge; no done is produced.
  - kill in the done cycle: done still asserts; state returns to idle.
  - kill together with mul at counter==0: no start.
- Counter never exceeds 7 and never wraps. An illegal op_funct3 (bit 2 set) is treated as MUL.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: if either latched operand is 0 at start:
  - counter jumps 1→5 on the next edge and result←0.
  - Completion still waits for LAT_LO/LAT_HI. Only the arithmetic steps are gated, saving power.
  - Externally visible counter sequence: 0,1,5,6(,7).
- Undefined: all steps always execute; counter sequence 0,1,2,3,4,5,6(,7).

Test Plan:
- MUL rs1=7, rs2=6, mul held high → counter 1..6; done=1 at counter 6 with result=0x0000002A; counter=0 next cycle.
- MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → done at counter 6, result=0x00000000. MULH 0x80000000×0x80000000 → result=0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → done at counter 7 (not 6), result=0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 → result=0xFFFFFFFF.
- Start MUL; change rs1/rs2/funct3 at counter 2 → result still matches the original operands; op_funct3 unchanged.
- Assert reset asynchronously at counter 3 → counter=0, busy=0, result=0 before the next clock edge. Assert kill at counter 4 → idle next cycle; done never asserts.
- Two consecutive MULs (3×5 then 4×4) → done twice with results 15 then 16; exactly one counter==0 cycle between them.
